// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX multi-cycle sequencer:
// opcodes, sequencer states, PC update commands and the decoded-instruction record.
package dlx_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQZ     = 6'h04;
  localparam logic [5:0] OP_BNEZ     = 6'h05;
  localparam logic [5:0] OP_JR       = 6'h12;
  localparam logic [5:0] OP_JALR     = 6'h13;
  localparam logic [5:0] OP_LOAD_LO  = 6'h20;
  localparam logic [5:0] OP_LOAD_HI  = 6'h25;
  localparam logic [5:0] OP_STORE_LO = 6'h28;
  localparam logic [5:0] OP_STORE_HI = 6'h2B;

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_REL = 2'b01,
    PC_ABS = 2'b11
  } pc_cmd_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_COMMIT,
    ST_TRAP
  } seq_state_t;

  typedef enum logic [3:0] {
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_J,
    CLS_JAL,
    CLS_BEQZ,
    CLS_BNEZ,
    CLS_JR,
    CLS_JALR,
    CLS_LOAD,
    CLS_STORE
  } instr_class_t;

  typedef struct packed {
    instr_class_t cls;
    logic         is_branch;
    logic         is_jump;
    logic         is_reg_jump;
    logic         is_load;
    logic         is_store;
    logic         writes_rf;
    logic         links;
    logic         illegal;
  } dec_t;

  // Standard DLX immediate ALU opcodes: ADDI..LHI and SLLI..SGEI.
  function automatic logic is_alu_imm(input logic [5:0] op);
    return ((op >= 6'h08) && (op <= 6'h0F)) || ((op >= 6'h14) && (op <= 6'h1D));
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] sext26(input logic [25:0] v);
    return {{6{v[25]}}, v};
  endfunction

endpackage

// File: rtl/dlx_opdecode.sv
// Combinational opcode classifier: maps IR[31:26] to an instruction class and control flags.
module dlx_opdecode
  import dlx_pkg::*;
(
  input  logic [5:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec     = '0;
    dec.cls = CLS_ALU_I;
    unique case (opcode)
      OP_RTYPE: begin
        dec.cls       = CLS_ALU_R;
        dec.writes_rf = 1'b1;
      end
      OP_J: begin
        dec.cls     = CLS_J;
        dec.is_jump = 1'b1;
      end
      OP_JAL: begin
        dec.cls       = CLS_JAL;
        dec.is_jump   = 1'b1;
        dec.writes_rf = 1'b1;
        dec.links     = 1'b1;
      end
      OP_BEQZ: begin
        dec.cls       = CLS_BEQZ;
        dec.is_branch = 1'b1;
      end
      OP_BNEZ: begin
        dec.cls       = CLS_BNEZ;
        dec.is_branch = 1'b1;
      end
      OP_JR: begin
        dec.cls         = CLS_JR;
        dec.is_reg_jump = 1'b1;
      end
      OP_JALR: begin
        dec.cls         = CLS_JALR;
        dec.is_reg_jump = 1'b1;
        dec.writes_rf   = 1'b1;
        dec.links       = 1'b1;
      end
      default: begin
        if ((opcode >= OP_LOAD_LO) && (opcode <= OP_LOAD_HI)) begin
          dec.cls       = CLS_LOAD;
          dec.is_load   = 1'b1;
          dec.writes_rf = 1'b1;
        end else if ((opcode >= OP_STORE_LO) && (opcode <= OP_STORE_HI)) begin
          dec.cls      = CLS_STORE;
          dec.is_store = 1'b1;
        end else if (is_alu_imm(opcode)) begin
          dec.writes_rf = 1'b1;
        end else begin
          // Unknown opcode: flagged only; the sequencer decides whether it traps or runs as I-type ALU.
          dec.illegal = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/dlx_seq_ctrl.sv
// Multi-cycle DLX control sequencer: FETCH -> DECODE -> EXEC -> {MEM} -> COMMIT.
// Optional macro DLX_SEQ_TRAP_EN: unknown opcodes enter a terminal TRAP state and a trap port is added.
module dlx_seq_ctrl
  import dlx_pkg::*;
#(
  parameter int unsigned RETIRE_W     = 32,
  parameter int unsigned IMEM_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                i_req,
  input  logic                i_valid,
  input  logic [31:0]         i_rdata,
  input  logic [31:0]         rs1_val,
  output logic                d_req,
  output logic                d_we,
  input  logic                d_ack,
  output logic                rf_we,
  output logic                rf_link,
  output logic                IF,
  output logic [1:0]          pc_cmd,
  output logic [31:0]         pc_v,
  output logic [RETIRE_W-1:0] retired,
  output logic                fetch_err
`ifdef DLX_SEQ_TRAP_EN
  ,
  output logic                trap
`endif
);

  seq_state_t state_q, state_d;
  logic       run_q;
  logic [31:0] ir_q;
  dec_t       dec, dec_q;
  logic [31:0] imm16_q, imm26_q;
  pc_cmd_t    cmd_q, cmd_d;
  logic [31:0] pcv_q, pcv_d;
  logic       taken;
  logic [31:0] tmo_q;

  dlx_opdecode u_dec (
    .opcode (ir_q[31:26]),
    .dec    (dec)
  );

  // run_q keeps i_req low through the first cycle after reset release.
  assign i_req   = run_q && (state_q == ST_FETCH);
  assign d_req   = (state_q == ST_MEM);
  assign d_we    = d_req && dec_q.is_store;
  assign IF      = (state_q == ST_COMMIT);
  assign rf_we   = IF && (dec_q.writes_rf || dec_q.illegal);
  assign rf_link = IF && dec_q.links;
  assign pc_cmd  = IF ? cmd_q : PC_INC;
  assign pc_v    = IF ? pcv_q : '0;

`ifdef DLX_SEQ_TRAP_EN
  assign trap = (state_q == ST_TRAP);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH:  if (i_req && i_valid) state_d = ST_DECODE;
      ST_DECODE: begin
        state_d = ST_EXEC;
`ifdef DLX_SEQ_TRAP_EN
        if (dec.illegal) state_d = ST_TRAP;
`endif
      end
      ST_EXEC:   state_d = (dec_q.is_load || dec_q.is_store) ? ST_MEM : ST_COMMIT;
      ST_MEM:    if (d_ack) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_FETCH;
    endcase
  end

  // BNEZ inverts the zero test; DLX targets are relative to PC+4.
  always_comb begin
    taken = dec_q.is_branch && ((rs1_val == '0) ^ (dec_q.cls == CLS_BNEZ));
    cmd_d = PC_INC;
    pcv_d = '0;
    if (dec_q.is_reg_jump) begin
      cmd_d = PC_ABS;
      pcv_d = rs1_val;
    end else if (dec_q.is_jump) begin
      cmd_d = PC_REL;
      pcv_d = imm26_q + 32'd4;
    end else if (taken) begin
      cmd_d = PC_REL;
      pcv_d = imm16_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      run_q   <= 1'b0;
      ir_q    <= '0;
      dec_q   <= '0;
      imm16_q <= '0;
      imm26_q <= '0;
      cmd_q   <= PC_INC;
      pcv_q   <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (i_req && i_valid) ir_q <= i_rdata;
      if (state_q == ST_DECODE) begin
        dec_q   <= dec;
        imm16_q <= sext16(ir_q[15:0]);
        imm26_q <= sext26(ir_q[25:0]);
      end
      if (state_q == ST_EXEC) begin
        cmd_q <= cmd_d;
        pcv_q <= pcv_d;
      end
      if (state_q == ST_COMMIT) retired <= retired + RETIRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q     <= '0;
      fetch_err <= 1'b0;
    end else if (i_req && !i_valid) begin
      if (tmo_q != '1) tmo_q <= tmo_q + 32'd1;
      if ((IMEM_TIMEOUT != 0) && ((tmo_q + 32'd1) >= 32'(IMEM_TIMEOUT))) fetch_err <= 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end

endmodule

// File: tb/tb_dlx_seq_ctrl.sv
// Self-checking bench for dlx_seq_ctrl: vector table plus scoreboard of expected commit pulses.
module tb_dlx_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_rdata = '0;
  logic [31:0] rs1_val = '0;
  logic        d_ack = 1'b0;
  logic        i_req, d_req, d_we, rf_we, rf_link, IF_o, fetch_err;
  logic [1:0]  pc_cmd;
  logic [31:0] pc_v, retired;
`ifdef DLX_SEQ_TRAP_EN
  logic        trap, t_trap;
`endif

  logic        t_zero = 1'b0;
  logic [31:0] t_zero32 = '0;
  logic        t_i_req, t_d_req, t_d_we, t_rf_we, t_rf_link, t_IF, t_fetch_err;
  logic [1:0]  t_pc_cmd;
  logic [31:0] t_pc_v, t_retired;

  always #5 clk = ~clk;

  dlx_seq_ctrl dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_valid(i_valid), .i_rdata(i_rdata),
    .rs1_val(rs1_val), .d_req(d_req), .d_we(d_we), .d_ack(d_ack), .rf_we(rf_we),
    .rf_link(rf_link), .IF(IF_o), .pc_cmd(pc_cmd), .pc_v(pc_v), .retired(retired),
    .fetch_err(fetch_err)
`ifdef DLX_SEQ_TRAP_EN
    , .trap(trap)
`endif
  );

  dlx_seq_ctrl #(.IMEM_TIMEOUT(3)) u_tmo (
    .clk(clk), .reset(reset), .i_req(t_i_req), .i_valid(t_zero), .i_rdata(t_zero32),
    .rs1_val(t_zero32), .d_req(t_d_req), .d_we(t_d_we), .d_ack(t_zero), .rf_we(t_rf_we),
    .rf_link(t_rf_link), .IF(t_IF), .pc_cmd(t_pc_cmd), .pc_v(t_pc_v), .retired(t_retired),
    .fetch_err(t_fetch_err)
`ifdef DLX_SEQ_TRAP_EN
    , .trap(t_trap)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    int          ack_wait;
    logic        mem;
    logic        dwe;
    logic [1:0]  cmd;
    logic [31:0] pcv;
    logic        we;
    logic        link;
  } vec_t;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] pcv;
    logic        we;
    logic        link;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] exp_retired = '0;
  bit          ret_pending = 1'b0;
  vec_t        vecs[18];
  vec_t        v_unk;
  logic [31:0] ret_base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Commit monitor: every IF pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (ret_pending) begin
        check("retired", 64'(retired), 64'(exp_retired));
        ret_pending = 1'b0;
      end
      if (IF_o) begin
        if (sb.size() == 0) begin
          check("IF_unexpected", 64'(IF_o), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("pc_cmd", 64'(pc_cmd), 64'(mon_e.cmd));
          check("pc_v", 64'(pc_v), 64'(mon_e.pcv));
          check("rf_we", 64'(rf_we), 64'(mon_e.we));
          check("rf_link", 64'(rf_link), 64'(mon_e.link));
          check("IF_cycle", 64'(cyc), 64'(mon_e.cyc));
          exp_retired = exp_retired + 32'd1;
          ret_pending = 1'b1;
        end
      end else begin
        check("strobe_idle", 64'({rf_we, rf_link}), 64'd0);
      end
    end
  end

  task automatic wait_ireq();
    for (int i = 0; i < 20; i++) begin
      if (i_req) break;
      @(negedge clk);
    end
    check("i_req_wait", 64'(i_req), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    wait_ireq();
    i_valid = 1'b1;
    i_rdata = v.instr;
    rs1_val = v.rs1;
    e.cmd  = v.cmd;
    e.pcv  = v.pcv;
    e.we   = v.we;
    e.link = v.link;
    e.cyc  = cyc + 3 + (v.mem ? 1 + v.ack_wait : 0);
    sb.push_back(e);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(posedge clk); #1;
    rs1_val = ~v.rs1;
    @(negedge clk);
    if (v.mem) begin
      check("d_req_on", 64'(d_req), 64'd1);
      check("d_we", 64'(d_we), 64'(v.dwe));
      for (int k = 0; k < v.ack_wait; k++) begin
        @(negedge clk);
        check("d_req_hold", 64'(d_req), 64'd1);
        check("d_we_hold", 64'(d_we), 64'(v.dwe));
      end
      d_ack = 1'b1;
      @(posedge clk); #1;
      d_ack = 1'b0;
      @(negedge clk);
      check("d_req_drop", 64'(d_req), 64'd0);
    end else begin
      check("d_req_idle", 64'(d_req), 64'd0);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
    end
    check("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    sb.delete();
    ret_pending = 1'b0;
    exp_retired = '0;
    i_valid = 1'b0;
    d_ack = 1'b0;
    #1;
    check("rst_retired", 64'(retired), 64'd0);
`ifdef DLX_SEQ_TRAP_EN
    check("rst_trap", 64'(trap), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    //          instr          rs1            ack mem dwe cmd    pc_v           we link
    vecs[0]  = '{32'h2000_0000, 32'h0000_0000, 0, 0, 0, 2'b00, 32'h0000_0000, 1, 0};
    vecs[1]  = '{32'h0000_0020, 32'h0000_0005, 0, 0, 0, 2'b00, 32'h0000_0000, 1, 0};
    vecs[2]  = '{32'h1000_FFF8, 32'h0000_0000, 0, 0, 0, 2'b01, 32'hFFFF_FFFC, 0, 0};
    vecs[3]  = '{32'h1000_FFF8, 32'h0000_0005, 0, 0, 0, 2'b00, 32'h0000_0000, 0, 0};
    vecs[4]  = '{32'h1400_0010, 32'h0000_0005, 0, 0, 0, 2'b01, 32'h0000_0014, 0, 0};
    vecs[5]  = '{32'h1400_0010, 32'h0000_0000, 0, 0, 0, 2'b00, 32'h0000_0000, 0, 0};
    vecs[6]  = '{32'h0A00_0000, 32'h0000_0077, 0, 0, 0, 2'b01, 32'hFE00_0004, 0, 0};
    vecs[7]  = '{32'h0C00_0100, 32'h0000_0000, 0, 0, 0, 2'b01, 32'h0000_0104, 1, 1};
    vecs[8]  = '{32'h4800_0000, 32'h0000_2000, 0, 0, 0, 2'b11, 32'h0000_2000, 0, 0};
    vecs[9]  = '{32'h4C00_0000, 32'h0000_1000, 0, 0, 0, 2'b11, 32'h0000_1000, 1, 1};
    vecs[10] = '{32'h8C00_0000, 32'h0000_0000, 0, 1, 0, 2'b00, 32'h0000_0000, 1, 0};
    vecs[11] = '{32'h8000_0004, 32'h0000_0000, 1, 1, 0, 2'b00, 32'h0000_0000, 1, 0};
    vecs[12] = '{32'h9400_0000, 32'h0000_0000, 2, 1, 0, 2'b00, 32'h0000_0000, 1, 0};
    vecs[13] = '{32'hAC00_0000, 32'h0000_0000, 3, 1, 1, 2'b00, 32'h0000_0000, 0, 0};
    vecs[14] = '{32'hA000_0000, 32'h0000_0000, 0, 1, 1, 2'b00, 32'h0000_0000, 0, 0};
    vecs[15] = '{32'h1000_FFFC, 32'h0000_0000, 0, 0, 0, 2'b01, 32'h0000_0000, 0, 0};
    vecs[16] = '{32'h09FF_FFFF, 32'h0000_0000, 0, 0, 0, 2'b01, 32'h0200_0003, 0, 0};
    vecs[17] = '{32'h1400_FFFF, 32'h8000_0000, 0, 0, 0, 2'b01, 32'h0000_0003, 0, 0};

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_i_req", 64'(i_req), 64'd0);
    check("rst_d_req", 64'(d_req), 64'd0);
    check("rst_d_we", 64'(d_we), 64'd0);
    check("rst_IF", 64'(IF_o), 64'd0);
    check("rst_rf", 64'({rf_we, rf_link}), 64'd0);
    check("rst_pc", 64'({pc_cmd, pc_v}), 64'd0);
    check("rst_retired0", 64'(retired), 64'd0);
    check("rst_fetch_err", 64'(fetch_err), 64'd0);
    check("rst_tmo_i_req", 64'(t_i_req), 64'd0);

    // Release; i_valid offered while i_req is still low must be ignored.
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    check("ireq_first_cycle", 64'(i_req), 64'd0);
    i_valid = 1'b1;
    i_rdata = 32'h4800_0000;
    @(posedge clk); #1 i_valid = 1'b0;
    @(negedge clk);
    check("ivalid_ignored_a", 64'(i_req), 64'd1);
    @(negedge clk);
    check("ivalid_ignored_b", 64'(i_req), 64'd1);
    @(negedge clk);
    check("tmo_before", 64'(t_fetch_err), 64'd0);
    @(negedge clk);
    check("tmo_set", 64'(t_fetch_err), 64'd1);
    check("tmo_ireq", 64'(t_i_req), 64'd1);
    repeat (4) @(negedge clk);
    check("tmo_sticky", 64'(t_fetch_err), 64'd1);
    check("tmo_ireq_held", 64'(t_i_req), 64'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Opcode 0x3F, outside the decoded set.
`ifdef DLX_SEQ_TRAP_EN
    wait_ireq();
    ret_base = retired;
    i_valid = 1'b1;
    i_rdata = 32'hFC00_0000;
    @(posedge clk); #1 i_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("trap_on", 64'(trap), 64'd1);
    check("trap_ireq", 64'(i_req), 64'd0);
    check("trap_dreq", 64'(d_req), 64'd0);
    check("trap_retired", 64'(retired), 64'(ret_base));
`else
    v_unk = '{32'hFC00_0000, 32'h0000_0000, 0, 0, 0, 2'b00, 32'h0000_0000, 1, 0};
    run_vec(v_unk);
`endif

    do_reset();

    // Reset asserted while a store waits for d_ack.
    run_vec(vecs[0]);
    wait_ireq();
    i_valid = 1'b1;
    i_rdata = 32'hAC00_0000;
    rs1_val = '0;
    @(posedge clk); #1 i_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (d_req) break;
      @(negedge clk);
    end
    check("abort_dreq_before", 64'(d_req), 64'd1);
    check("abort_retired_before", 64'(retired), 64'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    sb.delete();
    ret_pending = 1'b0;
    exp_retired = '0;
    #1;
    check("abort_dreq", 64'(d_req), 64'd0);
    check("abort_dwe", 64'(d_we), 64'd0);
    check("abort_IF", 64'(IF_o), 64'd0);
    check("abort_retired", 64'(retired), 64'd0);
    check("abort_ireq", 64'(i_req), 64'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("release_ireq_low", 64'(i_req), 64'd0);
    @(negedge clk);
    check("release_ireq_high", 64'(i_req), 64'd1);

    run_vec(vecs[9]);
    run_vec(vecs[13]);
    check("no_fetch_err", 64'(fetch_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dlx_seq_ctrl.md
Name: dlx_seq_ctrl

Overview:
- Multi-cycle control sequencer for the DLX core.
- Fetches each instruction over a request/valid instruction-memory handshake, classifies it, and drives the register file and data memory through a handshake.
- Commits the next-PC update by pulsing IF with the correct pc_cmd/pc_v to the program counter.
- One instruction in flight at a time; also keeps a retired-instruction count.

Parameters:
- RETIRE_W, 32, width of retired-instruction counter
- IMEM_TIMEOUT, 0, cycles to wait for i_valid before flagging fetch_err (0 = wait forever)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  out  1  instruction fetch request, level held until i_valid
- i_valid  in  1  instruction word valid on i_rdata
- i_rdata  in  32  instruction word
- rs1_val  in  32  register-file read of rs1, valid from DECODE onward
- d_req  out  1  data-memory request, level held until d_ack
- d_we  out  1  1 = store, 0 = load; valid while d_req
- d_ack  in  1  data access complete
- rf_we  out  1  register-file write strobe, one cycle
- rf_link  out  1  with rf_we: write PC+8 link value to r31 (JAL/JALR)
- IF  out  1  one-cycle PC update pulse
- pc_cmd  out  2  00 = +4, 01 = pc+pc_v (relative), 11 = pc_v (absolute)
- pc_v  out  32  PC operand
- retired  out  RETIRE_W  instructions committed since reset
- fetch_err  out  1  sticky fetch timeout flag

Behaviour:
- Reset value of all outputs: 0. State = FETCH. Async reset mid-transaction drops i_req/d_req in the same cycle; no IF pulse is issued for the aborted instruction.
- States: FETCH -> DECODE -> EXEC -> {MEM} -> COMMIT -> FETCH.
- FETCH:
  - i_req = 1.
  - On i_valid, latch i_rdata into the IR and go to DECODE.
  - i_valid without i_req is ignored.
- DECODE: one cycle.
  - Classify opcode IR[31:26]: 0x00 R-type ALU; 0x02 J; 0x03 JAL; 0x04 BEQZ; 0x05 BNEZ; 0x12 JR; 0x13 JALR; 0x20–0x25 load; 0x28–0x2B store; all other I-type ALU.
  - Latch sign-extended imm16 and imm26.
- EXEC: one cycle.
  - Sample rs1_val.
  - Resolve the branch: BEQZ taken iff rs1_val == 0; BNEZ taken iff rs1_val != 0.
  - Load/store go to MEM; everything else goes to COMMIT.
- MEM:
  - d_req = 1; d_we = 1 for store.
  - Hold until d_ack, then go to COMMIT.
  - d_ack in the same cycle MEM is entered counts.
- COMMIT: one cycle.
  - IF = 1. rf_we = 1 for ALU, load, JAL, JALR.
  - rf_link = 1 for JAL and JALR.
  - retired increments, wrapping modulo 2^RETIRE_W.
- PC selection in COMMIT:
  - Fall-through or not-taken branch: pc_cmd = 00, pc_v = 0.
  - Taken branch: pc_cmd = 01, pc_v = sext(imm16) + 4. DLX offsets are relative to PC+4; 32-bit wrap.
  - J/JAL: pc_cmd = 01, pc_v = sext(imm26) + 4.
  - JR/JALR: pc_cmd = 11, pc_v = rs1_val latched in EXEC.
- Latency: minimum 4 cycles per non-memory instruction with zero-wait i_valid; 5 cycles plus d_ack wait for memory instructions.
- Fetch timeout (IMEM_TIMEOUT > 0):
  - A counter runs while in FETCH and clears on i_valid.
  - On reaching IMEM_TIMEOUT, fetch_err is set (sticky until reset) and the sequencer stays in FETCH, still requesting.

Optional Feature:
- Macro: DLX_SEQ_TRAP_EN.
- Defined:
  - Opcodes outside the decoded set (instead of defaulting to I-type ALU) go to a TRAP state.
  - TRAP holds all strobes low, asserts an extra output port trap = 1, issues no IF pulse and does not increment retired.
  - Exit only by reset.
- Not defined: no trap port; unknown opcodes execute as I-type ALU (rf_we = 1, pc_cmd = 00).

Decomposition:
- dlx_pkg holds:
  - opcode localparams (OP_J, OP_JAL, OP_BEQZ, …)
  - state enum seq_state_t
  - pc_cmd encodings PC_INC / PC_REL / PC_ABS
  - instruction class enum
- Sub-module dlx_opdecode: combinational opcode -> class/flags (is_branch, is_jump, is_reg_jump, is_load, is_store, writes_rf, links, illegal).

Test Plan:
- ALU op 0x20000000-class, i_valid zero-wait -> IF pulse 4th cycle after i_req, pc_cmd = 00, rf_we = 1, retired 0 -> 1.
- BEQZ with imm16 = 0xFFF8, rs1_val = 0 -> pc_cmd = 01, pc_v = 0xFFFFFFFC; same with rs1_val = 5 -> pc_cmd = 00.
- JALR with rs1_val = 0x00001000 -> pc_cmd = 11, pc_v = 0x00001000, rf_we = rf_link = 1 in the IF cycle.
- Store with d_ack delayed 3 cycles -> d_req = d_we = 1 held exactly until d_ack, IF one cycle after d_ack, rf_we = 0.
- Reset asserted while d_req = 1 -> d_req, IF, retired all 0 immediately; after release, i_req = 1 next cycle.
- DLX_SEQ_TRAP_EN, opcode 0x3F -> trap = 1, no IF, retired unchanged; without macro -> IF with pc_cmd = 00, rf_we = 1.
